game_tick_scheduler: RTL and testbench

- Programmable tick scheduler for game timing; replaces ad-hoc free-running dividers.
- Divides the system clock into a base tick, then derives three per-subsystem tick strobes from it: ch0 bird physics, ch1 pipe scroll, ch2 score/blink.
- Owns run/pause/stop sequencing and a config port for divisors. Sits between top-level game control and the physics, scroll and display blocks.

---
 rtl/game_tick_scheduler.sv | 129 ++++++++++++
 tb/tb_game_tick_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Tick scheduler: divides clk into a base tick, then derives three per-channel
// tick strobes (ch0 physics, ch1 scroll, ch2 score/blink) with run/pause/stop control.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | stopped; prescaler, channel counters and frame_cnt held at zero
// RUN    | prescaler advancing, strobes emitted, config writes stalled
// PAUSED | everything frozen, config writes accepted
module game_tick_scheduler #(
    parameter int unsigned PRESCALE  = 500000,
    parameter int unsigned PW        = 20,
    parameter int unsigned DIV0_INIT = 1,
    parameter int unsigned DIV1_INIT = 2,
    parameter int unsigned DIV2_INIT = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_chan,
    input  logic [7:0]  cfg_div,
    output logic        base_tick,
    output logic [2:0]  tick,
    output logic [1:0]  state,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    DIV0_RST = 8'(DIV0_INIT);
    localparam logic [7:0]    DIV1_RST = 8'(DIV1_INIT);
    localparam logic [7:0]    DIV2_RST = 8'(DIV2_INIT);

    state_t        cur_state;
    state_t        nxt_state;
    logic [PW-1:0] prescaler;
    logic [7:0]    div [3];
    logic [7:0]    cnt [3];
    logic          advance;
    logic          base_event;
    logic          cfg_wr;

    always_comb begin
        nxt_state = cur_state;
        if (stop) begin
            nxt_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE:   if (start)  nxt_state = ST_RUN;
                ST_RUN:    if (pause)  nxt_state = ST_PAUSED;
                ST_PAUSED: if (!pause) nxt_state = ST_RUN;
                default:   nxt_state = ST_IDLE;
            endcase
        end
    end

    // Only count on edges that stay in RUN, so a strobe never lands outside RUN
    // and the edge that enters PAUSED freezes the period rather than consuming it.
    assign advance    = (cur_state == ST_RUN) && (nxt_state == ST_RUN);
    assign base_event = advance && (prescaler == PRE_LAST);
    assign cfg_ready  = (cur_state != ST_RUN);
    assign cfg_wr     = cfg_valid && cfg_ready;
    assign state      = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            prescaler <= '0;
            base_tick <= 1'b0;
            tick      <= '0;
            frame_cnt <= '0;
            div[0]    <= DIV0_RST;
            div[1]    <= DIV1_RST;
            div[2]    <= DIV2_RST;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cur_state <= nxt_state;
            base_tick <= 1'b0;
            tick      <= '0;

            if (nxt_state == ST_IDLE) begin
                prescaler <= '0;
                frame_cnt <= '0;
                for (int i = 0; i < 3; i++) begin
                    cnt[i] <= '0;
                end
            end else if (advance) begin
                if (base_event) begin
                    prescaler <= '0;
                    base_tick <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    for (int i = 0; i < 3; i++) begin
                        if (div[i] == 8'd0) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == div[i] - 8'd1) begin
                            tick[i] <= 1'b1;
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 8'd1;
                        end
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end

            // Writes are only accepted outside RUN, so they never race a base event.
            if (cfg_wr) begin
                for (int i = 0; i < 3; i++) begin
                    if (cfg_chan == 2'(i)) begin
                        div[i] <= cfg_div;
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with PRESCALE=4 and divisors 1/2/5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_game_tick_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        pause;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [7:0]  cfg_div;
    logic        base_tick;
    logic [2:0]  tick;
    logic [1:0]  state;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    game_tick_scheduler #(
        .PRESCALE (4),
        .PW       (3),
        .DIV0_INIT(1),
        .DIV1_INIT(2),
        .DIV2_INIT(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .base_tick(base_tick),
        .tick     (tick),
        .state    (state),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Quiet for gap-1 cycles, then base_tick with the given channel strobes.
    task automatic next_base(input int gap, input logic [2:0] exp_tick, input string tag);
        for (int k = 1; k < gap; k++) begin
            step();
            chk({tag, "_quiet"}, 16'({base_tick, tick}), 16'h0);
        end
        step();
        chk(tag, 16'({base_tick, tick}), 16'({1'b1, exp_tick}));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_div = 8'd0;
        step();
        step();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_strobes", 16'({base_tick, tick}), 16'h0);
        chk("rst_frame", frame_cnt, 16'd0);
        chk("rst_ready", 16'(cfg_ready), 16'd1);

        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("run_state", 16'(state), 16'd1);
        chk("run_ready", 16'(cfg_ready), 16'd0);
        for (int n = 1; n <= 10; n++) begin
            next_base(4, {(n % 5 == 0), (n % 2 == 0), 1'b1}, "run_tick");
        end
        chk("frame_10", frame_cnt, 16'd10);

        // pause with prescaler at 2
        step();
        step();
        pause = 1'b1;
        step();
        chk("pause_state", 16'(state), 16'd2);
        for (int i = 0; i < 19; i++) begin
            step();
            chk("pause_quiet", 16'({state, base_tick, tick}), 16'({2'd2, 4'h0}));
            chk("pause_frame", frame_cnt, 16'd10);
        end
        pause = 1'b0;
        step();
        chk("resume_state", 16'({state, base_tick}), 16'({2'd1, 1'b0}));
        next_base(2, 3'b001, "resume_tick");
        chk("frame_11", frame_cnt, 16'd11);

        // config write while paused: ch2 divisor -> 3
        pause = 1'b1;
        step();
        chk("paused_ready", 16'({state, cfg_ready}), 16'({2'd2, 1'b1}));
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd3;
        step();
        cfg_valid = 1'b0; pause = 1'b0;
        step();
        chk("resume2_state", 16'(state), 16'd1);
        next_base(4, 3'b011, "div3_a");
        next_base(4, 3'b001, "div3_b");
        next_base(4, 3'b111, "div3_c");

        // write held during RUN must stall; ch2 keeps divisor 3
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 8'd7;
        chk("run_stall_ready", 16'(cfg_ready), 16'd0);
        next_base(4, 3'b001, "stall_a");
        next_base(4, 3'b011, "stall_b");
        next_base(4, 3'b101, "stall_c");
        pause = 1'b1;
        step();
        chk("stall_ready", 16'({state, cfg_ready}), 16'({2'd2, 1'b1}));
        step();
        cfg_chan = 2'd1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0; pause = 1'b0;
        step();
        for (int m = 1; m <= 50; m++) begin
            next_base(4, {(m % 7 == 0), 1'b0, 1'b1}, "ch1_off");
        end
        chk("frame_67", frame_cnt, 16'd67);

        // stop and start together in RUN
        step();
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stop_state", 16'(state), 16'd0);
        chk("stop_frame", frame_cnt, 16'd0);
        chk("stop_strobes", 16'({base_tick, tick}), 16'h0);
        step();
        chk("idle_hold", 16'({state, base_tick}), 16'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_state", 16'(state), 16'd1);
        next_base(4, 3'b001, "restart_tick");
        chk("restart_frame", frame_cnt, 16'd1);

        // reset on the edge where prescaler is at its last value
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrun_rst_strobes", 16'({base_tick, tick}), 16'h0);
        chk("midrun_rst_state", 16'(state), 16'd0);
        chk("midrun_rst_frame", frame_cnt, 16'd0);
        chk("midrun_rst_ready", 16'(cfg_ready), 16'd1);
        reset = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            next_base(4, {(n % 5 == 0), (n % 2 == 0), 1'b1}, "init_div");
        end
        chk("frame_5", frame_cnt, 16'd5);

        // frame_cnt wrap
        pause = 1'b1;
        step();
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        chk("frame_forced", frame_cnt, 16'hFFFF);
        pause = 1'b0;
        step();
        next_base(4, 3'b011, "wrap_tick");
        chk("frame_wrap", frame_cnt, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
